// File: rtl/mmio_arb_pkg.sv
// Shared constants, FSM state type and grant-index width helper for the MMIO arbiter.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package mmio_arb_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ADDR_WIDTH = 22;
  localparam int DEF_DATA_WIDTH = 512;
  localparam int DEF_MAX_OUTST  = 4;

  // IDLE: grant follows round-robin each cycle. LOCKED: an offered request is pinned until accepted.
  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Bits needed to hold a requester index; at least one bit.
  function automatic int gnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_arb_fifo.sv
// In-order FIFO of grant indices, one entry per request still awaiting its response.
// Latency: an entry pushed on an edge is visible at dout from that edge on; count updates on the same edge.
// Backpressure: push is ignored while full and pop while empty; full/empty come from the registered count.
module mmio_arb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];
  assign count   = cnt_q;

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while the count says they are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/mmio_arb.sv
// Round-robin arbiter funnelling NUM_REQ MMIO requesters onto one shared target, responses returned in order.
// Latency: request and response paths are combinational; grant bookkeeping updates on the accepting edge.
// Backpressure: m_req_ready / s_rsp_ready pass straight through; requests stall while MAX_OUTST responses are pending.
module mmio_arb
  import mmio_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_OUTST  = DEF_MAX_OUTST
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                s_req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     s_req_addr,
  input  logic [NUM_REQ-1:0]                s_req_we,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   s_req_wbe,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     s_req_data,
  output logic [NUM_REQ-1:0]                s_req_ready,
  output logic [NUM_REQ-1:0]                s_rsp_ack,
  input  logic [NUM_REQ-1:0]                s_rsp_ready,
  output logic [DATA_WIDTH-1:0]             s_rsp_data,
  output logic                              s_rsp_error,
  output logic                              m_req_valid,
  output logic [ADDR_WIDTH-1:0]             m_req_addr,
  output logic                              m_req_we,
  output logic [DATA_WIDTH/8-1:0]           m_req_wbe,
  output logic [DATA_WIDTH-1:0]             m_req_data,
  input  logic                              m_req_ready,
  input  logic                              m_rsp_ack,
  input  logic [DATA_WIDTH-1:0]             m_rsp_data,
  input  logic                              m_rsp_error,
  output logic                              m_rsp_ready,
  output logic [$clog2(MAX_OUTST):0]        outst_cnt,
  output logic                              err_unexp_rsp
);

  localparam int GW = gnt_width(NUM_REQ);
  localparam int SW = DATA_WIDTH / 8;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [SW-1:0]         wbe;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] lock_gnt;
  logic [GW-1:0] gnt;
  logic [GW-1:0] cand;
  logic          gnt_vld;
  req_t          req_sel;
  logic          req_hs;
  logic          rsp_hs;
  logic          fifo_full;
  logic          fifo_empty;
  logic [GW-1:0] head;

  // Grant selection: the pinned index while locked, otherwise the first valid requester after last_grant.
  always_comb begin
    gnt     = lock_gnt;
    gnt_vld = 1'b0;
    cand    = '0;
    if (state == ARB_LOCKED) begin
      gnt_vld = s_req_valid[lock_gnt];
    end else begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        cand = GW'((int'(last_grant) + i) % NUM_REQ);
        if (!gnt_vld && s_req_valid[cand]) begin
          gnt     = cand;
          gnt_vld = 1'b1;
        end
      end
    end
  end

  // Route the granted requester to the target, return ready to it alone, and decide the lock transition.
  always_comb begin
    state_nxt   = state;
    req_sel     = '0;
    s_req_ready = '0;
    m_req_valid = gnt_vld & ~fifo_full;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt == GW'(i)) begin
        req_sel.addr   = s_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        req_sel.we     = s_req_we[i];
        req_sel.wbe    = s_req_wbe[i*SW +: SW];
        req_sel.data   = s_req_data[i*DATA_WIDTH +: DATA_WIDTH];
        s_req_ready[i] = m_req_valid & m_req_ready;
      end
    end
    case (state)
      ARB_IDLE:   if (m_req_valid && !m_req_ready) state_nxt = ARB_LOCKED;
      ARB_LOCKED: if (m_req_valid &&  m_req_ready) state_nxt = ARB_IDLE;
      default:    state_nxt = ARB_IDLE;
    endcase
  end

  assign m_req_addr = req_sel.addr;
  assign m_req_we   = req_sel.we;
  assign m_req_wbe  = req_sel.wbe;
  assign m_req_data = req_sel.data;
  assign req_hs     = m_req_valid & m_req_ready;

  // Lock state, the index pinned on entry to LOCKED, and the round-robin pointer (moves only on acceptance).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      lock_gnt   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE) begin
        lock_gnt <= gnt;
      end
      if (req_hs) begin
        last_grant <= gnt;
      end
    end
  end

  mmio_arb_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (GW)
  ) u_order (
    .clk   (clk),
    .rst   (rst),
    .push  (req_hs),
    .din   (gnt),
    .pop   (rsp_hs),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outst_cnt)
  );

  // Steer the target response to the oldest outstanding requester; drain when nothing is outstanding.
  always_comb begin
    s_rsp_ack   = '0;
    m_rsp_ready = 1'b1;
    if (!fifo_empty) begin
      m_rsp_ready = s_rsp_ready[head];
      for (int i = 0; i < NUM_REQ; i++) begin
        if (head == GW'(i)) begin
          s_rsp_ack[i] = m_rsp_ack;
        end
      end
    end
  end

  assign s_rsp_data  = m_rsp_data;
  assign s_rsp_error = m_rsp_error;
  assign rsp_hs      = m_rsp_ack & m_rsp_ready & ~fifo_empty;

  // A response with nothing outstanding is a target protocol error; remember it until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_unexp_rsp <= 1'b0;
    end else if (m_rsp_ack && fifo_empty) begin
      err_unexp_rsp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mmio_arb.sv
// Bench for mmio_arb: directed vector table, hand-written corner sequences, then randomized traffic
// checked against a queue-based reference model of arbitration order and response routing.
// Inputs change 1 ns after the rising edge; outputs are compared 2 ns after it.
module tb_mmio_arb;

  localparam int NR = 4;
  localparam int AW = 22;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     s_req_valid;
  logic [NR*AW-1:0]  s_req_addr;
  logic [NR-1:0]     s_req_we;
  logic [NR*SW-1:0]  s_req_wbe;
  logic [NR*DW-1:0]  s_req_data;
  logic [NR-1:0]     s_req_ready;
  logic [NR-1:0]     s_rsp_ack;
  logic [NR-1:0]     s_rsp_ready;
  logic [DW-1:0]     s_rsp_data;
  logic              s_rsp_error;
  logic              m_req_valid;
  logic [AW-1:0]     m_req_addr;
  logic              m_req_we;
  logic [SW-1:0]     m_req_wbe;
  logic [DW-1:0]     m_req_data;
  logic              m_req_ready;
  logic              m_rsp_ack;
  logic [DW-1:0]     m_rsp_data;
  logic              m_rsp_error;
  logic              m_rsp_ready;
  logic [2:0]        outst_cnt;
  logic              err_unexp_rsp;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mmio_arb #(
    .NUM_REQ    (NR),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_OUTST  (MO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_req_valid   (s_req_valid),
    .s_req_addr    (s_req_addr),
    .s_req_we      (s_req_we),
    .s_req_wbe     (s_req_wbe),
    .s_req_data    (s_req_data),
    .s_req_ready   (s_req_ready),
    .s_rsp_ack     (s_rsp_ack),
    .s_rsp_ready   (s_rsp_ready),
    .s_rsp_data    (s_rsp_data),
    .s_rsp_error   (s_rsp_error),
    .m_req_valid   (m_req_valid),
    .m_req_addr    (m_req_addr),
    .m_req_we      (m_req_we),
    .m_req_wbe     (m_req_wbe),
    .m_req_data    (m_req_data),
    .m_req_ready   (m_req_ready),
    .m_rsp_ack     (m_rsp_ack),
    .m_rsp_data    (m_rsp_data),
    .m_rsp_error   (m_rsp_error),
    .m_rsp_ready   (m_rsp_ready),
    .outst_cnt     (outst_cnt),
    .err_unexp_rsp (err_unexp_rsp)
  );

  typedef struct {
    logic [3:0]  vld;
    logic        mrdy;
    logic        rack;
    logic [3:0]  srdy;
    logic        mvld;
    logic [21:0] addr;
    logic [3:0]  sack;
    logic        mrrdy;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    s_req_valid = '0;
    m_req_ready = 1'b0;
    m_rsp_ack   = 1'b0;
    m_rsp_data  = '0;
    m_rsp_error = 1'b0;
    s_rsp_ready = '1;
    for (int i = 0; i < NR; i++) begin
      s_req_addr[i*AW +: AW] = AW'(32'h100 + i);
      s_req_we[i]            = i[0];
      s_req_wbe[i*SW +: SW]  = SW'(i + 1);
      s_req_data[i*DW +: DW] = DW'(32'hD0 + i);
    end
  endtask

  // Assert reset away from the edge, release 1 ns after the next rising edge.
  task automatic do_reset();
    clr_in();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic run_random(input int ncyc);
    int         q[$];
    int         last;
    int         held;
    int         g;
    int         c;
    int         h;
    bit         gv;
    bit         full;
    bit         exp_mvld;
    bit         exp_mrrdy;
    bit         do_pop;
    int         acc;
    logic [3:0] exp_srdy;
    logic [3:0] exp_sack;
    last = NR - 1;
    held = -1;
    for (int n = 0; n < ncyc; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!s_req_valid[i] && $urandom_range(0, 2) == 0) begin
          s_req_valid[i]         = 1'b1;
          s_req_addr[i*AW +: AW] = AW'($urandom);
          s_req_we[i]            = 1'($urandom_range(0, 1));
          s_req_wbe[i*SW +: SW]  = SW'($urandom_range(0, 15));
          s_req_data[i*DW +: DW] = DW'($urandom);
        end
      end
      m_req_ready = ($urandom_range(0, 3) != 0);
      s_rsp_ready = NR'($urandom);
      m_rsp_ack   = (q.size() > 0) ? ($urandom_range(0, 2) == 0) : 1'b0;
      m_rsp_data  = DW'($urandom);
      m_rsp_error = 1'($urandom_range(0, 1));
      #1;
      full = (q.size() >= MO);
      gv   = 1'b0;
      g    = 0;
      if (held >= 0) begin
        g  = held;
        gv = s_req_valid[g];
      end else begin
        for (int k = 1; k <= NR; k++) begin
          c = (last + k) % NR;
          if (!gv && s_req_valid[c]) begin
            g  = c;
            gv = 1'b1;
          end
        end
      end
      exp_mvld = gv && !full;
      exp_srdy = '0;
      if (exp_mvld && m_req_ready) exp_srdy[g] = 1'b1;
      exp_sack  = '0;
      exp_mrrdy = 1'b1;
      if (q.size() > 0) begin
        h         = q[0];
        exp_mrrdy = s_rsp_ready[h];
        exp_sack[h] = m_rsp_ack;
      end
      chk("rnd_m_req_valid", 64'(m_req_valid), 64'(exp_mvld));
      chk("rnd_s_req_ready", 64'(s_req_ready), 64'(exp_srdy));
      if (exp_mvld) begin
        chk("rnd_req_payload", 64'({m_req_addr, m_req_we, m_req_wbe, m_req_data}),
            64'({s_req_addr[g*AW +: AW], s_req_we[g], s_req_wbe[g*SW +: SW], s_req_data[g*DW +: DW]}));
      end
      chk("rnd_s_rsp_ack", 64'(s_rsp_ack), 64'(exp_sack));
      chk("rnd_m_rsp_ready", 64'(m_rsp_ready), 64'(exp_mrrdy));
      chk("rnd_rsp_pass", 64'({s_rsp_data, s_rsp_error}), 64'({m_rsp_data, m_rsp_error}));
      chk("rnd_outst_cnt", 64'(outst_cnt), 64'(q.size()));
      chk("rnd_err_unexp", 64'(err_unexp_rsp), 64'(0));
      do_pop = m_rsp_ack && exp_mrrdy && (q.size() > 0);
      if (do_pop) void'(q.pop_front());
      acc = -1;
      if (exp_mvld && m_req_ready) begin
        q.push_back(g);
        last = g;
        held = -1;
        acc  = g;
      end else if (exp_mvld) begin
        held = g;
      end
      step();
      if (acc >= 0) s_req_valid[acc] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            vld    mrdy  rack  srdy     mvld  addr      sack     mrrdy cnt
    tbl[0]  = '{4'hF,    1'b1, 1'b0, 4'b0001, 1'b1, 22'h100, 4'b0000, 1'b1, 3'd0};
    tbl[1]  = '{4'hF,    1'b1, 1'b1, 4'b0010, 1'b1, 22'h101, 4'b0001, 1'b1, 3'd1};
    tbl[2]  = '{4'hF,    1'b1, 1'b1, 4'b0100, 1'b1, 22'h102, 4'b0010, 1'b1, 3'd1};
    tbl[3]  = '{4'hF,    1'b1, 1'b1, 4'b1000, 1'b1, 22'h103, 4'b0100, 1'b1, 3'd1};
    tbl[4]  = '{4'hF,    1'b1, 1'b1, 4'b0001, 1'b1, 22'h100, 4'b1000, 1'b1, 3'd1};
    tbl[5]  = '{4'h0,    1'b1, 1'b1, 4'b0000, 1'b0, 22'h000, 4'b0001, 1'b1, 3'd1};
    tbl[6]  = '{4'h0,    1'b0, 1'b0, 4'b0000, 1'b0, 22'h000, 4'b0000, 1'b1, 3'd0};
    tbl[7]  = '{4'b1000, 1'b1, 1'b0, 4'b1000, 1'b1, 22'h103, 4'b0000, 1'b1, 3'd0};
    tbl[8]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 1'b1, 22'h102, 4'b0000, 1'b1, 3'd1};
    tbl[9]  = '{4'b0101, 1'b0, 1'b0, 4'b0000, 1'b1, 22'h102, 4'b0000, 1'b1, 3'd1};
    tbl[10] = '{4'b0101, 1'b0, 1'b0, 4'b0000, 1'b1, 22'h102, 4'b0000, 1'b1, 3'd1};
    tbl[11] = '{4'b0101, 1'b1, 1'b0, 4'b0100, 1'b1, 22'h102, 4'b0000, 1'b1, 3'd1};
    tbl[12] = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 22'h100, 4'b0000, 1'b1, 3'd2};
    tbl[13] = '{4'h0,    1'b0, 1'b1, 4'b0000, 1'b0, 22'h000, 4'b1000, 1'b1, 3'd3};
    tbl[14] = '{4'h0,    1'b0, 1'b1, 4'b0000, 1'b0, 22'h000, 4'b0100, 1'b1, 3'd2};
    tbl[15] = '{4'h0,    1'b0, 1'b1, 4'b0000, 1'b0, 22'h000, 4'b0001, 1'b1, 3'd1};
    tbl[16] = '{4'h0,    1'b0, 1'b0, 4'b0000, 1'b0, 22'h000, 4'b0000, 1'b1, 3'd0};

    // Reset state, observed while reset is held.
    clr_in();
    #2;
    rst = 1'b0;
    #2;
    chk("rst_m_req_valid", 64'(m_req_valid), 64'(0));
    chk("rst_s_req_ready", 64'(s_req_ready), 64'(0));
    chk("rst_s_rsp_ack", 64'(s_rsp_ack), 64'(0));
    chk("rst_m_rsp_ready", 64'(m_rsp_ready), 64'(1));
    chk("rst_outst_cnt", 64'(outst_cnt), 64'(0));
    chk("rst_err_unexp", 64'(err_unexp_rsp), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Directed table: round-robin rotation, lock against a newly valid requester, in-order responses.
    for (int r = 0; r < 17; r++) begin
      s_req_valid = tbl[r].vld;
      m_req_ready = tbl[r].mrdy;
      m_rsp_ack   = tbl[r].rack;
      m_rsp_data  = DW'(r);
      #1;
      chk($sformatf("tbl%0d_s_req_ready", r), 64'(s_req_ready), 64'(tbl[r].srdy));
      chk($sformatf("tbl%0d_m_req_valid", r), 64'(m_req_valid), 64'(tbl[r].mvld));
      if (tbl[r].mvld) chk($sformatf("tbl%0d_m_req_addr", r), 64'(m_req_addr), 64'(tbl[r].addr));
      chk($sformatf("tbl%0d_s_rsp_ack", r), 64'(s_rsp_ack), 64'(tbl[r].sack));
      chk($sformatf("tbl%0d_m_rsp_ready", r), 64'(m_rsp_ready), 64'(tbl[r].mrrdy));
      chk($sformatf("tbl%0d_outst_cnt", r), 64'(outst_cnt), 64'(tbl[r].cnt));
      step();
    end

    // Outstanding limit: four accepted, acceptance stops, a pop frees a slot only for the next cycle.
    do_reset();
    s_req_valid = 4'hF;
    m_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    #1;
    chk("full_outst_cnt", 64'(outst_cnt), 64'(4));
    chk("full_m_req_valid", 64'(m_req_valid), 64'(0));
    chk("full_s_req_ready", 64'(s_req_ready), 64'(0));
    m_rsp_ack = 1'b1;
    #1;
    chk("full_pop_s_rsp_ack", 64'(s_rsp_ack), 64'(4'b0001));
    chk("full_pop_s_req_ready", 64'(s_req_ready), 64'(0));
    step();
    m_rsp_ack = 1'b0;
    #1;
    chk("after_pop_outst_cnt", 64'(outst_cnt), 64'(3));
    chk("after_pop_m_req_valid", 64'(m_req_valid), 64'(1));
    chk("after_pop_s_req_ready", 64'(s_req_ready), 64'(4'b0001));
    step();

    // Response order and per-requester response backpressure.
    do_reset();
    s_req_valid = 4'b0010;
    m_req_ready = 1'b1;
    step();
    s_req_valid = 4'b1000;
    step();
    s_req_valid = 4'b0000;
    m_req_ready = 1'b0;
    s_rsp_ready = 4'b1101;
    m_rsp_ack   = 1'b1;
    m_rsp_data  = DW'(32'hA5);
    #1;
    chk("ord_stall_s_rsp_ack", 64'(s_rsp_ack), 64'(4'b0010));
    chk("ord_stall_m_rsp_ready", 64'(m_rsp_ready), 64'(0));
    chk("ord_stall_s_rsp_data", 64'(s_rsp_data), 64'(32'hA5));
    step();
    s_rsp_ready = 4'hF;
    #1;
    chk("ord_held_outst_cnt", 64'(outst_cnt), 64'(2));
    chk("ord_first_m_rsp_ready", 64'(m_rsp_ready), 64'(1));
    chk("ord_first_s_rsp_ack", 64'(s_rsp_ack), 64'(4'b0010));
    step();
    m_rsp_data  = DW'(32'h5A);
    m_rsp_error = 1'b1;
    #1;
    chk("ord_second_s_rsp_ack", 64'(s_rsp_ack), 64'(4'b1000));
    chk("ord_second_s_rsp_data", 64'(s_rsp_data), 64'(32'h5A));
    chk("ord_second_s_rsp_error", 64'(s_rsp_error), 64'(1));
    step();
    m_rsp_ack   = 1'b0;
    m_rsp_error = 1'b0;
    #1;
    chk("ord_done_outst_cnt", 64'(outst_cnt), 64'(0));

    // Unexpected response: drained, flagged, and the flag sticks.
    m_rsp_ack = 1'b1;
    #1;
    chk("unexp_s_rsp_ack", 64'(s_rsp_ack), 64'(0));
    chk("unexp_m_rsp_ready", 64'(m_rsp_ready), 64'(1));
    chk("unexp_err_before", 64'(err_unexp_rsp), 64'(0));
    step();
    m_rsp_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("unexp_err_sticky%0d", i), 64'(err_unexp_rsp), 64'(1));
      step();
    end

    // Reset with two requests outstanding discards them immediately.
    s_req_valid = 4'b0011;
    m_req_ready = 1'b1;
    step();
    step();
    s_req_valid = 4'b0000;
    m_req_ready = 1'b0;
    #1;
    chk("mid_outst_cnt", 64'(outst_cnt), 64'(2));
    chk("mid_err_still_set", 64'(err_unexp_rsp), 64'(1));
    rst = 1'b0;
    #1;
    chk("mid_rst_outst_cnt", 64'(outst_cnt), 64'(0));
    chk("mid_rst_m_req_valid", 64'(m_req_valid), 64'(0));
    chk("mid_rst_m_rsp_ready", 64'(m_rsp_ready), 64'(1));
    chk("mid_rst_err_clear", 64'(err_unexp_rsp), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_rsp_ack = 1'b1;
    #1;
    chk("post_rst_s_rsp_ack", 64'(s_rsp_ack), 64'(0));
    chk("post_rst_m_rsp_ready", 64'(m_rsp_ready), 64'(1));
    step();

    // Randomized traffic against the reference model.
    do_reset();
    run_random(600);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_arb.md
MMIO_ARB -- requirements
Module: mmio_arb

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
  NUM_REQ, 4, number of upstream requesters (2..8)
  ADDR_WIDTH, 22, MMIO address width
  DATA_WIDTH, 512, MMIO data width
  MAX_OUTST, 4, maximum accepted-but-unanswered requests (power of two)
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock; all logic on rising edge
  rst  in  1  asynchronous active-low reset
  s_req_valid  in  NUM_REQ  per-requester request valid
  s_req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester address
  s_req_we  in  NUM_REQ  per-requester write enable
  s_req_wbe  in  NUM_REQ*DATA_WIDTH/8  per-requester write byte strobes
  s_req_data  in  NUM_REQ*DATA_WIDTH  per-requester write data
  s_req_ready  out  NUM_REQ  per-requester request accept
  s_rsp_ack  out  NUM_REQ  per-requester response valid
  s_rsp_ready  in  NUM_REQ  per-requester response accept
  s_rsp_data  out  DATA_WIDTH  response data, broadcast to all
  s_rsp_error  out  1  response error, broadcast to all
  m_req_valid, m_req_addr, m_req_we, m_req_wbe, m_req_data  out  1/ADDR_WIDTH/1/DATA_WIDTH/8/DATA_WIDTH  request to shared MMIO target
  m_req_ready  in  1  target request accept
  m_rsp_ack, m_rsp_data, m_rsp_error  in  1/DATA_WIDTH/1  target response
  m_rsp_ready  out  1  response accept to target
  outst_cnt  out  $clog2(MAX_OUTST)+1  current outstanding count
  err_unexp_rsp  out  1  sticky: target response arrived with nothing outstanding

Function
REQ-003 Request handshake SHALL be valid&ready on the same edge; requesters hold valid and payload stable until accepted.
REQ-004 Arbitration SHALL be round-robin: search starts at index last_grant+1 (mod NUM_REQ); last_grant resets to NUM_REQ-1 so index 0 wins first.
REQ-005 Request path SHALL be zero-latency: m_req_* equals the granted requester's fields combinationally; s_req_ready[g] = m_req_ready for the granted g only, 0 elsewhere.
REQ-006 Lock: once m_req_valid is driven for grant g without m_req_ready, grant SHALL stay g (state LOCKED) until the handshake; new higher-priority valids SHALL NOT switch it. States: IDLE (no lock) -> LOCKED on valid&!ready; LOCKED -> IDLE on handshake.
REQ-007 last_grant SHALL update only on a request handshake.
REQ-008 On each request handshake the grant index SHALL be pushed into an in-order order FIFO (depth MAX_OUTST).
REQ-009 When the FIFO is full (registered count == MAX_OUTST), m_req_valid and all s_req_ready SHALL be 0; a same-cycle response pop SHALL NOT enable a push that cycle.
REQ-010 Response routing: with FIFO non-empty and head h, s_rsp_ack[h] = m_rsp_ack, m_rsp_ready = s_rsp_ready[h]; other s_rsp_ack bits 0; s_rsp_data/error pass through combinationally.
REQ-011 FIFO SHALL pop on m_rsp_ack&m_rsp_ready; simultaneous push and pop SHALL leave count unchanged.
REQ-012 With FIFO empty, m_rsp_ready SHALL be 1 (drain), all s_rsp_ack 0, and a m_rsp_ack SHALL set err_unexp_rsp (cleared only by reset).
REQ-013 outst_cnt SHALL equal FIFO occupancy, 0..MAX_OUTST, never wrapping.

Reset
REQ-014 On rst low, asynchronously: FIFO empty, outst_cnt 0, state IDLE, last_grant NUM_REQ-1, err_unexp_rsp 0; hence m_req_valid 0, all s_req_ready 0, all s_rsp_ack 0, m_rsp_ready 1.
REQ-015 Reset mid-transaction SHALL discard all outstanding entries; no response routing after release until a new handshake.

Structure
REQ-016 Package mmio_arb_pkg SHALL hold default parameter constants and the grant-index width function.
REQ-017 Order FIFO SHALL be sub-module mmio_arb_fifo (push/pop/full/empty/count, async active-low reset).

Verification
REQ-018 Requesters 0..3 all valid, m_req_ready=1 continuously -> grants 0,1,2,3,0 on consecutive cycles.
REQ-019 Requester 2 valid, m_req_ready=0 for 3 cycles, requester 0 raises valid cycle 1 -> grant stays 2 until handshake, then 0 granted.
REQ-020 Four accepted requests (MAX_OUTST=4), no responses -> outst_cnt=4, m_req_valid=0, s_req_ready=0; one response -> count 3, next cycle acceptance resumes.
REQ-021 Requests from 1 then 3, responses data 0xA5 then 0x5A -> s_rsp_ack[1] with 0xA5, then s_rsp_ack[3] with 0x5A; s_rsp_ready[1]=0 stalls m_rsp_ready.
REQ-022 m_rsp_ack=1 with outst_cnt=0 -> err_unexp_rsp=1 and stays until reset.
REQ-023 rst low with outst_cnt=2 -> outst_cnt=0, m_req_valid=0, m_rsp_ready=1 immediately.
